// File: rtl/kryssprodukt_pkg.sv
// kryssprodukt_pkg: shared definitions for the sequential cross/dot-product engine.
//   - state_e   : engine FSM states (idle, calculating, result held)
//   - mac_op_e  : accumulator operation applied by kryss_mac
//   - dst_e     : result register written by the current step
//   - step constants for the last step of each sequence
//   - calc_ow() : result component width for a given operand width
package kryssprodukt_pkg;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    typedef enum logic [1:0] {MacLoad, MacAdd, MacSub} mac_op_e;

    typedef enum logic [1:0] {DstX, DstY, DstZ} dst_e;

    typedef logic [2:0] step_t;

    localparam step_t STEP_LAST_CROSS = 3'd5;
    localparam step_t STEP_LAST_DOT   = 3'd2;

    // A W x W signed product needs 2W bits; one extra bit covers the
    // difference of two products or the sum of three.
    function automatic int unsigned calc_ow(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/kryss_mac.sv
// kryss_mac: one signed W x W multiplier feeding an OW-bit accumulate stage.
// Optional feature macro: KRYSS_DOT_EN (enables the add path used by dot mode).
// Ports:
//   op_a, op_b  in  W   signed multiplier operands
//   acc         in  OW  current value of the destination register
//   op          in  2   MacLoad (res = a*b), MacAdd (res = acc + a*b), MacSub (res = acc - a*b)
//   res         out OW  next value for the destination register
module kryss_mac
    import kryssprodukt_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned OW = calc_ow(W)
) (
    input  logic [W-1:0]  op_a,
    input  logic [W-1:0]  op_b,
    input  logic [OW-1:0] acc,
    input  mac_op_e       op,
    output logic [OW-1:0] res
);

    logic signed [2*W-1:0] prod_raw;
    logic [OW-1:0]         prod;

    assign prod_raw = $signed(op_a) * $signed(op_b);
    assign prod     = {{(OW - 2 * W){prod_raw[2*W-1]}}, prod_raw};

    always_comb begin
        res = prod;
        case (op)
            MacLoad: res = prod;
`ifdef KRYSS_DOT_EN
            MacAdd:  res = acc + prod;
`endif
            MacSub:  res = acc - prod;
            default: res = prod;
        endcase
    end

endmodule

// File: rtl/kryssprodukt_seq.sv
// kryssprodukt_seq: sequential 3-D signed cross-product engine sharing one multiplier.
// Cross product takes six multiply steps; with KRYSS_DOT_EN defined a dot product
// (mode=1) takes three steps and leaves cy/cz at zero.
// Optional feature macro: KRYSS_DOT_EN (adds the mode port and dot-product sequence).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready is combinational from out_ready)
//   ax..az, bx..bz       signed operand vectors a and b, W bits each
//   mode                 0 = cross, 1 = dot (only with KRYSS_DOT_EN)
//   out_valid/out_ready  result handshake; result held while out_ready is low
//   cx, cy, cz           signed result vector, OW = 2W+1 bits each
module kryssprodukt_seq
    import kryssprodukt_pkg::*;
#(
    parameter int unsigned W  = 8,
    localparam int unsigned OW = calc_ow(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  ax,
    input  logic [W-1:0]  ay,
    input  logic [W-1:0]  az,
    input  logic [W-1:0]  bx,
    input  logic [W-1:0]  by,
    input  logic [W-1:0]  bz,
`ifdef KRYSS_DOT_EN
    input  logic          mode,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] cx,
    output logic [OW-1:0] cy,
    output logic [OW-1:0] cz
);

    state_e state_q, state_d;
    step_t  step_q, step_d;

    logic [W-1:0]  ax_q, ay_q, az_q, bx_q, by_q, bz_q;
    logic [OW-1:0] cx_q, cy_q, cz_q;
    logic [OW-1:0] cx_d, cy_d, cz_d;
    logic          mode_q;

    logic          accept;
    step_t         last_step;

    logic [W-1:0]  mac_a, mac_b;
    logic [OW-1:0] mac_acc, mac_res;
    mac_op_e       mac_op;
    dst_e          dst;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign last_step = mode_q ? STEP_LAST_DOT : STEP_LAST_CROSS;

    assign cx = cx_q;
    assign cy = cy_q;
    assign cz = cz_q;

    // Operand and destination selection for the current step.
    always_comb begin
        mac_a  = '0;
        mac_b  = '0;
        mac_op = MacLoad;
        dst    = DstX;
`ifdef KRYSS_DOT_EN
        if (mode_q) begin
            case (step_q)
                3'd0: begin mac_a = ax_q; mac_b = bx_q; mac_op = MacLoad; dst = DstX; end
                3'd1: begin mac_a = ay_q; mac_b = by_q; mac_op = MacAdd;  dst = DstX; end
                3'd2: begin mac_a = az_q; mac_b = bz_q; mac_op = MacAdd;  dst = DstX; end
                default: ;
            endcase
        end else
`endif
        begin
            case (step_q)
                3'd0: begin mac_a = ay_q; mac_b = bz_q; mac_op = MacLoad; dst = DstX; end
                3'd1: begin mac_a = az_q; mac_b = by_q; mac_op = MacSub;  dst = DstX; end
                3'd2: begin mac_a = az_q; mac_b = bx_q; mac_op = MacLoad; dst = DstY; end
                3'd3: begin mac_a = ax_q; mac_b = bz_q; mac_op = MacSub;  dst = DstY; end
                3'd4: begin mac_a = ax_q; mac_b = by_q; mac_op = MacLoad; dst = DstZ; end
                3'd5: begin mac_a = ay_q; mac_b = bx_q; mac_op = MacSub;  dst = DstZ; end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (dst)
            DstX:    mac_acc = cx_q;
            DstY:    mac_acc = cy_q;
            default: mac_acc = cz_q;
        endcase
    end

    kryss_mac #(
        .W  (W),
        .OW (OW)
    ) u_mac (
        .op_a (mac_a),
        .op_b (mac_b),
        .acc  (mac_acc),
        .op   (mac_op),
        .res  (mac_res)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cz_d    = cz_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCalc;
                    step_d  = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                    cz_d    = '0;
                end
            end
            StCalc: begin
                case (dst)
                    DstX:    cx_d = mac_res;
                    DstY:    cy_d = mac_res;
                    default: cz_d = mac_res;
                endcase
                if (step_q == last_step) begin
                    state_d = StDone;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = StCalc;
                        step_d  = '0;
                        cx_d    = '0;
                        cy_d    = '0;
                        cz_d    = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            cz_q    <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            az_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            bz_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cz_q    <= cz_d;
            if (accept) begin
                ax_q <= ax;
                ay_q <= ay;
                az_q <= az;
                bx_q <= bx;
                by_q <= by;
                bz_q <= bz;
            end
        end
    end

`ifdef KRYSS_DOT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (accept) begin
            mode_q <= mode;
        end
    end
`else
    assign mode_q = 1'b0;
`endif

endmodule

// File: tb/tb_kryssprodukt_seq.sv
// tb_kryssprodukt_seq: directed self-checking bench for kryssprodukt_seq (W = 8).
// Dot-product steps run only when KRYSS_DOT_EN is defined.
module tb_kryssprodukt_seq;

    localparam int unsigned W  = 8;
    localparam int unsigned OW = 2 * W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  ax, ay, az, bx, by, bz;
`ifdef KRYSS_DOT_EN
    logic          mode;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] cx, cy, cz;

    int checks = 0;
    int errors = 0;

    kryssprodukt_seq #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ax        (ax),
        .ay        (ay),
        .az        (az),
        .bx        (bx),
        .by        (by),
        .bz        (bz),
`ifdef KRYSS_DOT_EN
        .mode      (mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cx        (cx),
        .cy        (cy),
        .cz        (cz)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int ex, input int ey, input int ez);
        chk({tag, ".cx"}, $signed(cx), ex);
        chk({tag, ".cy"}, $signed(cy), ey);
        chk({tag, ".cz"}, $signed(cz), ez);
    endtask

    task automatic set_ops(input int a0, input int a1, input int a2,
                           input int b0, input int b1, input int b2);
        ax = W'(a0); ay = W'(a1); az = W'(a2);
        bx = W'(b0); by = W'(b1); bz = W'(b2);
    endtask

    logic [OW-1:0] hold_x, hold_y, hold_z;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef KRYSS_DOT_EN
        mode      = 1'b0;
`endif
        set_ops(0, 0, 0, 0, 0, 0);

        // Reset state
        #3;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk_res("rst", 0, 0, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("idle.in_ready", in_ready, 1);
        chk("idle.out_valid", out_valid, 0);

        // Cross product (2,4,6) x (3,5,7) = (-2,4,-2), 6-cycle latency
        set_ops(2, 4, 6, 3, 5, 7);
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        set_ops(9, 9, 9, 9, 9, 9);   // ignored while calculating
        chk("calc.in_ready", in_ready, 0);
        out_ready = 1'b1;            // no effect outside DONE
        tick(5);
        chk("cross.early_valid", out_valid, 0);
        out_ready = 1'b0;
        tick(1);
        chk("cross.valid", out_valid, 1);
        chk_res("cross", -2, 4, -2);

        // Backpressure: held for 5 cycles, outputs stable, in_ready low
        hold_x = cx; hold_y = cy; hold_z = cz;
        in_valid = 1'b1;
        set_ops(0, -128, -128, 0, 127, -128);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("bp.out_valid", out_valid, 1);
            chk("bp.in_ready", in_ready, 0);
            chk("bp.cx_stable", $signed(cx), $signed(hold_x));
            chk("bp.cy_stable", $signed(cy), $signed(hold_y));
            chk("bp.cz_stable", $signed(cz), $signed(hold_z));
        end
        // Release with new operands waiting: accepted in the same cycle
        out_ready = 1'b1;
        #1;
        chk("bp.release_in_ready", in_ready, 1);
        tick(1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp.accepted", out_valid, 0);
        chk_res("bp.cleared", 0, 0, 0);

        // Extreme values: (0,-128,-128) x (0,127,-128) = (32640,0,0)
        tick(6);
        chk("ext.valid", out_valid, 1);
        chk_res("ext", 32640, 0, 0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("drain.out_valid", out_valid, 0);
        chk("drain.in_ready", in_ready, 1);

        // Reset at step 3 discards the partial result
        set_ops(2, 4, 6, 3, 5, 7);
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(3);
        chk("pre_rst.cy", $signed(cy), 18);
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.in_ready", in_ready, 1);
        chk_res("midrst", 0, 0, 0);
        #1;
        rst = 1'b0;
        tick(1);
        chk("postrst.out_valid", out_valid, 0);
        set_ops(1, 0, 0, 0, 1, 0);
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(6);
        chk("unit.valid", out_valid, 1);
        chk_res("unit", 0, 0, 1);

        // Back-to-back with out_ready held: results 7 cycles apart
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_ops(2, 4, 6, 3, 5, 7);
        tick(1);
        set_ops(1, 2, 3, 4, 5, 6);
        tick(5);
        chk("b2b1.early_valid", out_valid, 0);
        tick(1);
        chk("b2b1.valid", out_valid, 1);
        chk("b2b1.in_ready", in_ready, 1);
        chk_res("b2b1", -2, 4, -2);
        tick(1);
        in_valid = 1'b0;
        chk("b2b2.accepted", out_valid, 0);
        tick(5);
        chk("b2b2.early_valid", out_valid, 0);
        tick(1);
        chk("b2b2.valid", out_valid, 1);
        chk_res("b2b2", -3, 6, -3);
        tick(1);
        out_ready = 1'b0;
        chk("b2b.idle", out_valid, 0);

`ifdef KRYSS_DOT_EN
        // Dot product (2,4,6).(3,5,7) = 68, 3-cycle latency
        set_ops(2, 4, 6, 3, 5, 7);
        mode     = 1'b1;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        mode     = 1'b0;
        tick(2);
        chk("dot.early_valid", out_valid, 0);
        tick(1);
        chk("dot.valid", out_valid, 1);
        chk_res("dot", 68, 0, 0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
